acc_load_unpack: RTL and testbench

- Reverse path of the accumulator store/saturation stage.
- Accepts 16-bit memory words over a valid/ready stream and assembles them into a 40-bit accumulator value.
- Sign-extends the result into the 8 guard bits.
- Presents the result to the accumulator write port over a second valid/ready handshake.
- Sits between the data-memory read port and the MAC accumulator register file.

---
 rtl/acc_load_unpack.sv | 173 +++++++++++++++++
 tb/tb_acc_load_unpack.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_load_unpack.sv
// -----------------------------------------------------------------------------
// acc_load_unpack
//
// Reverse path of the accumulator store/saturation stage. Memory words arrive
// over a valid/ready stream and are assembled into one ACC_W-bit accumulator
// value. The value is sign-extended into the guard bits and offered to the
// accumulator write port over a second valid/ready stream.
//
// Load formats (mode_i, sampled together with start_i):
//   2'b00  single fractional : acc = {guard sext, w, WORD_W zeros}
//   2'b01  single integer    : acc = sign-extended w
//   2'b10  double            : acc = {guard sext, hi, lo}, hi arrives first
//   2'b11  reserved          : rejected, sets the sticky err_o flag
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   reset_n_i     asynchronous active-low reset
//   start_i       request a new load (taken in IDLE, or in OUT at handshake)
//   mode_i        load format, see above
//   word_valid_i  word_i is valid
//   word_i        memory word
//   word_ready_o  unit accepts a word this cycle
//   acc_valid_o   acc_o holds an assembled value
//   acc_o         assembled, sign-extended accumulator value
//   acc_ready_i   accumulator port consumes acc_o
//   busy_o        high in any state other than IDLE
//   err_o         sticky reserved-mode error flag
//   state_o       debug view of the FSM state
//                 (0 IDLE, 1 WAIT_HI, 2 WAIT_LO, 3 OUT)
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. word_ready_o and acc_valid_o are
// decoded from registered state only, so neither depends combinationally on
// word_valid_i or acc_ready_i.
// -----------------------------------------------------------------------------
module acc_load_unpack #(
   parameter int WORD_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic              word_valid_i,
   input  logic [WORD_W-1:0] word_i,
   output logic              word_ready_o,
   output logic              acc_valid_o,
   output logic [ACC_W-1:0]  acc_o,
   input  logic              acc_ready_i,
   output logic              busy_o,
   output logic              err_o,
   output logic [1:0]        state_o
);

   localparam int GUARD_W = ACC_W - 2*WORD_W;

   localparam logic [1:0] MODE_FRAC   = 2'b00;
   localparam logic [1:0] MODE_INT    = 2'b01;
   localparam logic [1:0] MODE_DOUBLE = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t             state_q;
   logic [1:0]         mode_q;
   logic [WORD_W-1:0]  hi_q;
   logic [ACC_W-1:0]   acc_q;
   logic               err_q;

   // Single-word formats. Only the fractional/integer distinction matters
   // here; the double format is assembled in WAIT_LO.
   function automatic logic [ACC_W-1:0] assemble_single(
      input logic [1:0]        mode,
      input logic [WORD_W-1:0] w
   );
      logic [ACC_W-1:0] res;
      if (mode == MODE_INT) begin
         res = {{(ACC_W-WORD_W){w[WORD_W-1]}}, w};
      end else begin
         res = {{GUARD_W{w[WORD_W-1]}}, w, {WORD_W{1'b0}}};
      end
      return res;
   endfunction

   // The low word of a double load is raw magnitude bits; only hi carries
   // the sign into the guard bits.
   function automatic logic [ACC_W-1:0] assemble_double(
      input logic [WORD_W-1:0] hi,
      input logic [WORD_W-1:0] lo
   );
      return {{GUARD_W{hi[WORD_W-1]}}, hi, lo};
   endfunction

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         mode_q  <= 2'b00;
         hi_q    <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (mode_i == MODE_RSVD) begin
                     err_q <= 1'b1;
                  end else begin
                     mode_q  <= mode_i;
                     err_q   <= 1'b0;
                     state_q <= WAIT_HI;
                  end
               end
            end

            // start_i is deliberately ignored while words are being
            // collected: a load in progress is never aborted.
            WAIT_HI: begin
               if (word_valid_i) begin
                  if (mode_q == MODE_DOUBLE) begin
                     hi_q    <= word_i;
                     state_q <= WAIT_LO;
                  end else begin
                     acc_q   <= assemble_single(mode_q, word_i);
                     state_q <= OUT;
                  end
               end
            end

            WAIT_LO: begin
               if (word_valid_i) begin
                  acc_q   <= assemble_double(hi_q, word_i);
                  state_q <= OUT;
               end
            end

            // A start request coinciding with the output handshake chains
            // straight into the next load without passing through IDLE.
            OUT: begin
               if (acc_ready_i) begin
                  if (start_i && (mode_i != MODE_RSVD)) begin
                     mode_q  <= mode_i;
                     err_q   <= 1'b0;
                     state_q <= WAIT_HI;
                  end else begin
                     if (start_i) begin
                        err_q <= 1'b1;
                     end
                     state_q <= IDLE;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state; reset therefore drops
   // busy_o / word_ready_o / acc_valid_o without waiting for a clock.
   assign word_ready_o = (state_q == WAIT_HI) || (state_q == WAIT_LO);
   assign acc_valid_o  = (state_q == OUT);
   assign busy_o       = (state_q != IDLE);
   assign acc_o        = acc_q;
   assign err_o        = err_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_acc_load_unpack.sv
// -----------------------------------------------------------------------------
// tb_acc_load_unpack
//
// Self-checking bench for acc_load_unpack. Drivers push the expected
// accumulator value of every load into exp_q; a monitor on the falling edge
// pops and compares on every output handshake, and also checks that acc_o is
// held while valid is stalled. Expected values come from an arithmetic model
// (signed word scaled by 2^16 etc.), not from bit slicing.
// -----------------------------------------------------------------------------
module tb_acc_load_unpack;

   localparam int WORD_W = 16;
   localparam int ACC_W  = 40;

   logic              clk_i;
   logic              reset_n_i;
   logic              start_i;
   logic [1:0]        mode_i;
   logic              word_valid_i;
   logic [WORD_W-1:0] word_i;
   logic              word_ready_o;
   logic              acc_valid_o;
   logic [ACC_W-1:0]  acc_o;
   logic              acc_ready_i = 1'b0;
   logic              busy_o;
   logic              err_o;
   logic [1:0]        state_o;

   logic [ACC_W-1:0]  exp_q[$];
   int                n_checks = 0;
   int                n_fail   = 0;

   logic              rdy_rand  = 1'b0;
   logic              rdy_fixed = 1'b0;

   acc_load_unpack #(.WORD_W(WORD_W), .ACC_W(ACC_W)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .word_ready_o (word_ready_o),
      .acc_valid_o  (acc_valid_o),
      .acc_o        (acc_o),
      .acc_ready_i  (acc_ready_i),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .state_o      (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // acc_ready_i driver: random back-pressure or a fixed level
   always @(posedge clk_i) begin
      #2;
      acc_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
   end

   // ---------------- reference model ----------------
   function automatic logic [ACC_W-1:0] model_acc(input int mode, input int hi, input int lo);
      longint s;
      longint v;
      s = (hi >= 32768) ? longint'(hi) - 65536 : longint'(hi);
      case (mode)
         0:       v = s * 65536;
         1:       v = s;
         default: v = s * 65536 + longint'(lo);
      endcase
      return v[ACC_W-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic             hold_pend = 1'b0;
   logic [ACC_W-1:0] hold_val  = '0;

   always @(negedge clk_i) begin
      if (!reset_n_i) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", 64'(acc_valid_o), 64'd1);
            check("hold_stable", 64'(acc_o), 64'(hold_val));
         end
         if (acc_valid_o && acc_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got 0x%0h expected none at %0t", acc_o, $time);
            end else begin
               check("acc_value", 64'(acc_o), 64'(exp_q.pop_front()));
            end
         end
         hold_pend = acc_valid_o && !acc_ready_i;
         hold_val  = acc_o;
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks begin and end 1 time unit after a rising edge.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_phase(input logic [1:0] mode);
      logic acc;
      logic ok;
      ok      = 1'b0;
      start_i = 1'b1;
      mode_i  = mode;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         acc = !busy_o || (acc_valid_o && acc_ready_i);
         @(posedge clk_i);
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      start_i = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL start_timeout: got no accept expected accept at %0t", $time);
      end
   endtask

   task automatic word_phase(input logic [WORD_W-1:0] w, input int gmax);
      int   gap;
      logic acc;
      logic ok;
      ok  = 1'b0;
      gap = $urandom_range(0, gmax);
      repeat (gap) next_cycle();
      word_valid_i = 1'b1;
      word_i       = w;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         acc = word_ready_o;
         @(posedge clk_i);
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      word_valid_i = 1'b0;
      word_i       = $urandom_range(0, 65535);
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL word_timeout: got no accept expected accept at %0t", $time);
      end
   endtask

   task automatic do_load(input int mode, input int hi, input int lo, input int gmax);
      exp_q.push_back(model_acc(mode, hi, lo));
      start_phase(2'(mode));
      word_phase(WORD_W'(hi), gmax);
      if (mode == 2) word_phase(WORD_W'(lo), gmax);
      // result must be visible in the cycle right after the last word
      @(negedge clk_i);
      check("valid_after_last_word", 64'(acc_valid_o), 64'd1);
      next_cycle();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!busy_o) break;
         next_cycle();
      end
      check("reached_idle", 64'(busy_o), 64'd0);
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int idx_last;
      int cnt;
      logic acc;
      logic [WORD_W-1:0] w;

      reset_n_i    = 1'b0;
      start_i      = 1'b0;
      mode_i       = 2'b00;
      word_valid_i = 1'b0;
      word_i       = '0;

      // reset values while held and after release
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_word_ready", 64'(word_ready_o), 64'd0);
      check("rst_acc_valid", 64'(acc_valid_o), 64'd0);
      check("rst_acc", 64'(acc_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      next_cycle();
      check("rel_state", 64'(state_o), 64'd0);
      check("rel_acc_valid", 64'(acc_valid_o), 64'd0);
      check("rel_busy", 64'(busy_o), 64'd0);

      // single fractional
      rdy_fixed = 1'b1;
      next_cycle();
      do_load(0, 16'h8001, 0, 0);
      check("frac_neg_model", 64'(model_acc(0, 16'h8001, 0)), 64'hFF80010000);
      do_load(0, 16'h7FFF, 0, 0);

      // double with word gaps and a stalled consumer
      wait_idle();
      rdy_fixed = 1'b0;
      next_cycle();
      do_load(2, 16'h8000, 16'hFFFF, 3);
      repeat (3) next_cycle();
      @(negedge clk_i);
      check("stall_valid", 64'(acc_valid_o), 64'd1);
      check("stall_word_ready", 64'(word_ready_o), 64'd0);
      check("stall_acc", 64'(acc_o), 64'hFF8000FFFF);
      next_cycle();
      rdy_fixed = 1'b1;
      wait_idle();
      do_load(2, 16'h7FFF, 16'h0000, 0);

      // reserved mode in IDLE, then cleared by a valid start
      wait_idle();
      rdy_fixed = 1'b0;
      next_cycle();
      start_i = 1'b1;
      mode_i  = 2'b11;
      next_cycle();
      start_i = 1'b0;
      @(negedge clk_i);
      check("rsvd_err", 64'(err_o), 64'd1);
      check("rsvd_idle", 64'(state_o), 64'd0);
      check("rsvd_word_ready", 64'(word_ready_o), 64'd0);
      next_cycle();
      exp_q.push_back(model_acc(1, 16'hFFFE, 0));
      start_phase(2'b01);
      @(negedge clk_i);
      check("err_cleared", 64'(err_o), 64'd0);
      check("int_busy", 64'(busy_o), 64'd1);
      next_cycle();
      word_phase(16'hFFFE, 0);
      // reserved start while holding a result: ignored until the handshake
      start_i = 1'b1;
      mode_i  = 2'b11;
      repeat (2) next_cycle();
      @(negedge clk_i);
      check("out_start_ignored_err", 64'(err_o), 64'd0);
      check("out_start_ignored_valid", 64'(acc_valid_o), 64'd1);
      next_cycle();
      rdy_fixed = 1'b1;
      wait_idle();
      start_i = 1'b0;
      check("out_rsvd_err", 64'(err_o), 64'd1);
      do_load(1, 16'h1234, 0, 0);

      // back-to-back fractional loads, continuous stream, consumer always ready
      wait_idle();
      next_cycle();
      start_i      = 1'b1;
      mode_i       = 2'b00;
      word_valid_i = 1'b1;
      w            = 16'($urandom_range(0, 65535));
      word_i       = w;
      cnt          = 0;
      idx_last     = -1;
      for (int idx = 0; idx < 40; idx++) begin
         @(negedge clk_i);
         acc = word_ready_o;
         if (idx >= 1) begin
            check("b2b_busy", 64'(busy_o), 64'd1);
            check("b2b_valid_pattern", 64'(acc_valid_o), 64'((idx % 2) == 0));
         end
         @(posedge clk_i);
         if (acc) begin
            exp_q.push_back(model_acc(0, int'(w), 0));
            cnt++;
            if (cnt == 8) begin
               idx_last = idx;
               break;
            end
            #1;
            w      = 16'($urandom_range(0, 65535));
            word_i = w;
         end
      end
      #1;
      start_i      = 1'b0;
      word_valid_i = 1'b0;
      check("b2b_cycles", 64'(idx_last), 64'd15);
      next_cycle();

      // reset in WAIT_LO drops outputs asynchronously
      wait_idle();
      next_cycle();
      start_phase(2'b10);
      word_phase(16'h8000, 0);
      @(negedge clk_i);
      check("pre_rst_word_ready", 64'(word_ready_o), 64'd1);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("async_busy", 64'(busy_o), 64'd0);
      check("async_word_ready", 64'(word_ready_o), 64'd0);
      check("async_acc_valid", 64'(acc_valid_o), 64'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      next_cycle();
      check("post_rst_state", 64'(state_o), 64'd0);
      check("post_rst_valid", 64'(acc_valid_o), 64'd0);
      check("post_rst_acc", 64'(acc_o), 64'd0);

      // randomized loads under random back-pressure
      rdy_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         do_load($urandom_range(0, 2), $urandom_range(0, 65535), $urandom_range(0, 65535), 2);
      end

      // drain
      rdy_rand  = 1'b0;
      rdy_fixed = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0 && !busy_o) break;
         next_cycle();
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      check("drain_idle", 64'(busy_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
